// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and limits for the add/sub library
// Contents:
//   state_t    serial subtractor FSM state encoding (IDLE/SHIFT/DONE)
//   WIDTH_MIN  smallest legal operand width
//   WIDTH_MAX  largest legal operand width
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full-subtractor cell
// Ports:
//   a     in   minuend bit
//   b     in   subtrahend bit
//   bin   in   borrow in
//   d     out  difference bit a - b - bin
//   bout  out  borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor, DIFF = A - B, LSB first
// Optional feature macro: SUB_OVF_EN adds the signed overflow output ovf.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start_valid/start_ready  operand request handshake, a/b sampled on accept
//   a, b                     minuend, subtrahend (WIDTH bits)
//   done_valid/done_ready    result handshake
//   diff                     A - B modulo 2^WIDTH, held while done_valid
//   bout                     final borrow, 1 iff A < B unsigned
//   ovf                      signed overflow (SUB_OVF_EN builds only)
module serial_subtractor
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             borrow_next;
`ifdef SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .d    (d_bit),
        .bout (borrow_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            done_valid  <= 1'b0;
            diff        <= '0;
            bout        <= 1'b0;
            a_sr        <= '0;
            b_sr        <= '0;
            borrow      <= 1'b0;
            cnt         <= '0;
`ifdef SUB_OVF_EN
            ovf         <= 1'b0;
            a_msb       <= 1'b0;
            b_msb       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_sr        <= a;
                        b_sr        <= b;
                        borrow      <= 1'b0;
                        cnt         <= '0;
                        start_ready <= 1'b0;
                        state       <= SHIFT;
`ifdef SUB_OVF_EN
                        // Operand MSBs are shifted away, so keep copies.
                        a_msb       <= a[WIDTH-1];
                        b_msb       <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    // Result bits enter at the top so the LSB lands at bit 0
                    // after WIDTH shifts.
                    diff   <= {d_bit, diff[WIDTH-1:1]};
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    borrow <= borrow_next;
                    if (cnt == CNT_LAST) begin
                        bout       <= borrow_next;
                        done_valid <= 1'b1;
                        state      <= DONE;
`ifdef SUB_OVF_EN
                        // d_bit is the result MSB on the final shift.
                        ovf        <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        done_valid  <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    done_valid  <= 1'b0;
                    start_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         done_valid;
    logic         done_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .diff        (diff),
`ifdef SUB_OVF_EN
        .ovf         (ovf),
`endif
        .bout        (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete operation. The model works on whole integers: the
    // difference wraps modulo 2^W, the borrow is plain unsigned compare and
    // overflow is a signed-range test on the true signed difference.
    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input int stall_in, input bit early, input bit probe);
        int n;
        int lat;
        int stall;
        int sd;
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        ed = W'((int'(ai) - int'(bi)) % 256 + 256);
        eb = (int'(ai) < int'(bi));
        sd = int'($signed(ai)) - int'($signed(bi));
        eo = (sd > 127) || (sd < -128);
        stall = early ? 0 : stall_in;

        a = ai;
        b = bi;
        start_valid = 1'b1;
        n = 0;
        while (!start_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_wait", 32'(n < 200), 32'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        if (early) done_ready = 1'b1;

        lat = 0;
        while (!done_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, W);
        check("diff", 32'(diff), 32'(ed));
        check("bout", 32'(bout), 32'(eb));
`ifdef SUB_OVF_EN
        check("ovf", 32'(ovf), 32'(eo));
`else
        if (eo) n = 0;
`endif

        for (int i = 0; i < stall; i++) begin
            if (probe) begin
                start_valid = 1'b1;
                a = 8'hFF;
                b = 8'h00;
            end
            @(posedge clk); #1;
            check("stall_valid", 32'(done_valid), 32'd1);
            check("stall_diff", 32'(diff), 32'(ed));
            check("stall_bout", 32'(bout), 32'(eb));
            if (probe) check("stall_ready", 32'(start_ready), 32'd0);
        end
        start_valid = 1'b0;
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        check("release_valid", 32'(done_valid), 32'd0);
        check("release_ready", 32'(start_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        start_valid = 1'b0;
        done_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
`ifdef SUB_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(8'h5A, 8'h3C, 0, 1'b0, 1'b0);
        do_op(8'h00, 8'h01, 0, 1'b0, 1'b0);
        do_op(8'h37, 8'h37, 0, 1'b0, 1'b0);
        do_op(8'h80, 8'h01, 0, 1'b0, 1'b0);
        do_op(8'h7F, 8'hFF, 1, 1'b0, 1'b0);
        do_op(8'hC3, 8'h12, 5, 1'b0, 1'b1);

        // Reset during the fourth shift cycle, then a clean operation.
        a = 8'h55;
        b = 8'h11;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", 32'(start_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(start_ready), 32'd1);
        check("mid_rst_valid", 32'(done_valid), 32'd0);
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_bout", 32'(bout), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(8'h10, 8'h01, 0, 1'b0, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
